// File: rtl/me_sched_pkg.sv
// Shared types and helpers for the motion-estimation job scheduler.
//   sched_state_e  : scheduler FSM states
//   DIST_NOMATCH   : BestDist value the core reports when no block matched
//   RUN_CYCLES_DEF : default core run window (one full sequential SAD search)
//   sign_mv()      : raw two's-complement motion vector -> signed value
package me_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StSettle,
      StCapture,
      StResp
   } sched_state_e;

   localparam logic [7:0]  DIST_NOMATCH   = 8'hFF;
   localparam int unsigned RUN_CYCLES_DEF = 4112;
   localparam int unsigned MV_MAX_W       = 8;

   // Interpret the low w bits of raw as two's complement: raw >= 2^(w-1) maps to raw - 2^w.
   function automatic logic signed [MV_MAX_W-1:0] sign_mv(input logic [MV_MAX_W-1:0] raw,
                                                          input int unsigned          w);
      int v;
      v = int'(raw);
      if (v >= (1 << (w - 1))) begin
         v = v - (1 << w);
      end
      return v[MV_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps; the first set
// request wins. The pointer register is owned by the parent.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot winner (all zero when no request)
//   id  : index of the winner (zero when no request)
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    id
);

   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      gnt   = '0;
      id    = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((32'(ptr) + 32'(i)) % NUM_REQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            id       = idx;
         end
      end
   end

endmodule

// File: rtl/me_job_scheduler.sv
// Shares one motion-estimation core among NUM_REQ requesters. A round-robin winner gets
// the memory-load path (grant/mem_sel), then the core start level is held for RUN_CYCLES,
// the result is captured after one settle cycle and returned with the requester id.
//   clock, reset          : clock and asynchronous active-high reset
//   req, load_done        : per-requester level request / end-of-load pulse
//   grant, mem_sel        : one-hot load grant (LOAD only), memory mux select
//   core_start            : core start level (RUN only)
//   core_BestDist/motionX/motionY : raw core results
//   rsp_*                 : valid/ready response with id, distance, signed vectors, flags
//   busy                  : scheduler not idle
module me_job_scheduler
   import me_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned RUN_CYCLES = RUN_CYCLES_DEF,
   parameter int unsigned DIST_W     = 8,
   parameter int unsigned MV_W       = 4,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       load_done,
   output logic [NUM_REQ-1:0]       grant,
   output logic [ID_W-1:0]          mem_sel,
   output logic                     core_start,
   input  logic [DIST_W-1:0]        core_BestDist,
   input  logic [MV_W-1:0]          core_motionX,
   input  logic [MV_W-1:0]          core_motionY,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DIST_W-1:0]        rsp_dist,
   output logic signed [MV_W-1:0]   rsp_mx,
   output logic signed [MV_W-1:0]   rsp_my,
   output logic                     rsp_nomatch,
   output logic                     rsp_perfect,
   output logic                     busy
);

   localparam logic [12:0] RunLast = 13'(RUN_CYCLES - 1);

   sched_state_e         state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [12:0]          cnt_q, cnt_d;
   logic                 cap_en;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [ID_W-1:0]      arb_id;
   logic signed [MV_MAX_W-1:0] mx_full, my_full;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .id  (arb_id)
   );

   assign mx_full = sign_mv(MV_MAX_W'(core_motionX), MV_W);
   assign my_full = sign_mv(MV_MAX_W'(core_motionY), MV_W);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      id_d       = id_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      cap_en     = 1'b0;
      grant      = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StLoad;
               gnt_d   = arb_gnt;
               id_d    = arb_id;
               // Pointer moves past the winner now, so an aborted load still yields priority.
               ptr_d   = ID_W'((32'(arb_id) + 32'd1) % NUM_REQ);
            end
         end
         StLoad: begin
            grant = gnt_q;
            if (|(load_done & gnt_q)) begin
               state_d = StRun;
            end else if (!(|(req & gnt_q))) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            core_start = 1'b1;
            if (cnt_q == RunLast) begin
               cnt_d   = '0;
               state_d = StSettle;
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         StSettle: begin
            state_d = StCapture;
         end
         StCapture: begin
            cap_en  = 1'b1;
            state_d = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         id_q        <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         rsp_id      <= '0;
         rsp_dist    <= '0;
         rsp_mx      <= '0;
         rsp_my      <= '0;
         rsp_nomatch <= 1'b0;
         rsp_perfect <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         if (cap_en) begin
            rsp_id      <= id_q;
            rsp_dist    <= core_BestDist;
            rsp_mx      <= mx_full[MV_W-1:0];
            rsp_my      <= my_full[MV_W-1:0];
            rsp_nomatch <= &core_BestDist;
            rsp_perfect <= (core_BestDist == '0);
         end
      end
   end

   assign mem_sel = id_q;

endmodule

// File: tb/tb_me_job_scheduler.sv
module tb_me_job_scheduler;

   logic              clock = 1'b0;
   logic              reset;
   logic [3:0]        req, load_done, grant;
   logic [1:0]        mem_sel, rsp_id;
   logic              core_start, rsp_valid, rsp_ready, rsp_nomatch, rsp_perfect, busy;
   logic [7:0]        core_BestDist, rsp_dist;
   logic [3:0]        core_motionX, core_motionY;
   logic signed [3:0] rsp_mx, rsp_my;

   int errors = 0;
   int checks = 0;
   int ptr    = 0;   // model round-robin pointer

   me_job_scheduler #(
      .NUM_REQ    (4),
      .RUN_CYCLES (4112),
      .DIST_W     (8),
      .MV_W       (4),
      .ID_W       (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .load_done     (load_done),
      .grant         (grant),
      .mem_sel       (mem_sel),
      .core_start    (core_start),
      .core_BestDist (core_BestDist),
      .core_motionX  (core_motionX),
      .core_motionY  (core_motionY),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_dist      (rsp_dist),
      .rsp_mx        (rsp_mx),
      .rsp_my        (rsp_my),
      .rsp_nomatch   (rsp_nomatch),
      .rsp_perfect   (rsp_perfect),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // First requester at or after p, wrapping; -1 if none.
   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         int idx;
         idx = (p + i) % 4;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_start"}, core_start, 0);
      check({tag, "_valid"}, rsp_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_memsel"}, mem_sel, 0);
      check({tag, "_rsp"}, {rsp_id, rsp_dist, rsp_mx, rsp_my, rsp_nomatch, rsp_perfect}, 0);
   endtask

   // One job: request, load, run, response. reset_at > 0 resets after that many start cycles.
   task automatic run_job(input logic [3:0] r, input bit keep, input logic [7:0] d,
                          input logic [3:0] x, input logic [3:0] y, input int bp,
                          input int reset_at);
      int eid, n, nstart, vx, vy;
      bit seen, gbad;
      logic [3:0] eg;
      logic signed [3:0] ex, ey;
      req = r;
      eid = pick(r, ptr);
      ptr = (eid + 1) % 4;
      eg  = 4'b0001 << eid;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cyc();
         seen = |grant;
      end
      check("grant_seen", seen, 1);
      check("grant", grant, eg);
      check("mem_sel", mem_sel, eid);
      check("busy_load", busy, 1);
      core_BestDist = d;
      core_motionX  = x;
      core_motionY  = y;
      load_done = ~eg;          // other requesters' pulses must be ignored
      cyc();
      load_done = '0;
      check("grant_hold", grant, eg);
      check("start_in_load", core_start, 0);
      repeat ($urandom_range(0, 2)) cyc();
      load_done = eg;
      cyc();
      load_done = '0;
      if (!keep) req = '0;      // req changes during RUN are ignored
      nstart = core_start ? 1 : 0;
      n      = 0;
      gbad   = 1'b0;
      while (!rsp_valid && n < 5000) begin
         if (reset_at > 0 && nstart == reset_at) break;
         cyc();
         n++;
         if (core_start) nstart++;
         if (|grant) gbad = 1'b1;
      end
      if (reset_at > 0) begin
         check("start_before_reset", core_start, 1);
         #1 reset = 1'b1;
         #1;
         check_reset_values("midrun");
         ptr = 0;
         cyc();
         cyc();
         reset = 1'b0;
         return;
      end
      check("latency", n, 4114);
      check("start_cycles", nstart, 4112);
      check("grant_in_run", gbad, 0);
      vx = int'(x);
      if (vx >= 8) vx -= 16;
      vy = int'(y);
      if (vy >= 8) vy -= 16;
      ex = vx[3:0];
      ey = vy[3:0];
      check("rsp_id", rsp_id, eid);
      check("rsp_dist", rsp_dist, d);
      check("rsp_mx", rsp_mx, ex);
      check("rsp_my", rsp_my, ey);
      check("rsp_nomatch", rsp_nomatch, (d == 8'hFF) ? 1 : 0);
      check("rsp_perfect", rsp_perfect, (d == 8'h00) ? 1 : 0);
      for (int k = 0; k < bp; k++) begin
         cyc();
         check("bp_valid", rsp_valid, 1);
         check("bp_fields", {rsp_id, rsp_dist, rsp_mx, rsp_my}, {eid[1:0], d, ex, ey});
         check("bp_grant", grant, 0);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      check("valid_after_accept", rsp_valid, 0);
      check("idle_after_accept", busy, 0);
   endtask

   initial begin
      bit saw_start, saw_valid;
      reset         = 1'b1;
      req           = '0;
      load_done     = '0;
      rsp_ready     = 1'b0;
      core_BestDist = '0;
      core_motionX  = '0;
      core_motionY  = '0;
      #2;
      check_reset_values("reset");
      cyc();
      reset = 1'b0;
      cyc();

      // Round robin with all requesters held: ids 0,1,2,3,0.
      for (int j = 0; j < 5; j++) begin
         run_job(4'b1111, (j < 4), 8'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 3), 0);
      end

      // Sign correction and perfect match.
      run_job(4'b0100, 1'b0, 8'h00, 4'hD, 4'h3, 0, 0);

      // No match with 10 cycles of backpressure.
      run_job(4'b0001, 1'b0, 8'hFF, 4'h8, 4'h7, 10, 0);

      // Abort: requester 1 drops its request during LOAD.
      req = 4'b0010;
      cyc();
      check("abort_grant", grant, 4'b0010);
      ptr = 2;
      cyc();
      req = '0;
      cyc();
      check("abort_idle", busy, 0);
      check("abort_grant_clr", grant, 0);
      saw_start = 1'b0;
      saw_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         saw_start |= core_start;
         saw_valid |= rsp_valid;
      end
      check("abort_no_start", saw_start, 0);
      check("abort_no_rsp", saw_valid, 0);

      // Pointer advanced past 1 despite the abort, so 2 wins.
      run_job(4'b0110, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 1, 0);

      // Reset in the middle of RUN, then a full job from a cleared pointer.
      run_job(4'b0100, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 0, 1000);
      run_job(4'b1100, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
